// File: rtl/branch_resolver_pkg.sv
// Shared types and parameter defaults for the branch resolver.
// Optional statistics counters are enabled by defining BRANCH_RESOLVER_STATS_EN.
package branch_resolver_pkg;

   localparam int DEPTH_DEF = 4;   // in-flight predictions (power of two, 2..16)
   localparam int IDX_W_DEF = 4;   // branch-number width
   localparam int CNT_W_DEF = 16;  // statistics counter width

   // RUN: normal operation. FLUSH: one cycle spent discarding younger predictions.
   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_e;

   // One in-flight prediction, laid out at the default branch-number width.
   typedef struct packed {
      logic [IDX_W_DEF-1:0] idx;
      logic                 taken;
   } entry_t;

endpackage

// File: rtl/branch_resolver_fifo.sv
// Program-order FIFO of in-flight predictions with a single-cycle flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module branch_resolver_fifo
   import branch_resolver_pkg::*;
#(
   parameter int  DEPTH = DEPTH_DEF,
   parameter type T     = entry_t
) (
   input  logic clk,
   input  logic reset,
   input  logic i_push,
   input  logic i_pop,
   input  logic i_flush,
   input  T     i_data,
   output T     o_head,
   output logic o_full,
   output logic o_empty
);

   localparam int              PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

   T                 r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

   // Entry storage, written only on an accepted push.
   // NOTE: the data array has no reset; occupancy alone decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy; a flush drops every entry at once.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: queues predictions, compares them with actual outcomes in
// program order, trains the predictor and flushes on a mispredict.
// Define BRANCH_RESOLVER_STATS_EN to build the saturating statistics counters;
// otherwise mismatch_cnt and branch_cnt are tied to zero.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int IDX_W = IDX_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pred_valid,
   output logic             pred_ready,
   input  logic [IDX_W-1:0] pred_idx,
   input  logic             pred_taken,
   input  logic             res_valid,
   input  logic             res_taken,
   output logic             upd_valid,
   output logic [IDX_W-1:0] upd_idx,
   output logic             upd_taken,
   output logic             mispredict,
   output logic             orphan_err,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] branch_cnt
);

   // Same field layout as entry_t, sized to this instance's IDX_W.
   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             taken;
   } slot_t;

   state_e           r_state;
   logic             r_armed;
   logic             r_upd_valid;
   logic [IDX_W-1:0] r_upd_idx;
   logic             r_upd_taken;
   logic             r_mispredict;
   logic             r_orphan_err;

   slot_t w_head;
   slot_t w_push_data;
   logic  w_full;
   logic  w_empty;
   logic  w_run;
   logic  w_flush;
   logic  w_push;
   logic  w_pop;
   logic  w_orphan;
   logic  w_miss;

   assign w_run       = (r_state == RUN);
   assign w_flush     = (r_state == FLUSH);
   // r_armed keeps pred_ready low from reset until the first edge after release.
   assign pred_ready  = r_armed && w_run && !w_full;
   assign w_push      = pred_valid && pred_ready;
   assign w_pop       = res_valid && w_run && !w_empty;
   assign w_orphan    = res_valid && w_run && w_empty;
   assign w_miss      = w_pop && (w_head.taken != res_taken);
   assign w_push_data = '{idx: pred_idx, taken: pred_taken};

   branch_resolver_fifo #(
      .DEPTH (DEPTH),
      .T     (slot_t)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (w_push_data),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Control FSM with registered training, mispredict and orphan outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= RUN;
         r_armed      <= 1'b0;
         r_upd_valid  <= 1'b0;
         r_upd_idx    <= '0;
         r_upd_taken  <= 1'b0;
         r_mispredict <= 1'b0;
         r_orphan_err <= 1'b0;
      end else begin
         r_armed      <= 1'b1;
         r_upd_valid  <= w_pop;
         r_mispredict <= w_miss;
         r_orphan_err <= w_orphan;
         if (w_pop) begin
            r_upd_idx   <= w_head.idx;
            r_upd_taken <= res_taken;
         end
         if (w_flush) begin
            r_state <= RUN;
         end else if (w_miss) begin
            r_state <= FLUSH;
         end
      end
   end

   assign upd_valid  = r_upd_valid;
   assign upd_idx    = r_upd_idx;
   assign upd_taken  = r_upd_taken;
   assign mispredict = r_mispredict;
   assign orphan_err = r_orphan_err;

`ifdef BRANCH_RESOLVER_STATS_EN
   logic [CNT_W-1:0] r_branch_cnt;
   logic [CNT_W-1:0] r_mismatch_cnt;

   // Saturating counts of resolved branches and of mispredicts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_branch_cnt   <= '0;
         r_mismatch_cnt <= '0;
      end else begin
         if (w_pop && (r_branch_cnt != '1)) begin
            r_branch_cnt <= r_branch_cnt + 1'b1;
         end
         if (w_miss && (r_mismatch_cnt != '1)) begin
            r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
         end
      end
   end

   assign branch_cnt   = r_branch_cnt;
   assign mismatch_cnt = r_mismatch_cnt;
`else
   assign branch_cnt   = '0;
   assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed vector table, a mid-flight
// reset sequence and a randomized run against a queue-based reference model.
module tb_branch_resolver;

   localparam int DEPTH   = 4;
   localparam int IDX_W   = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef BRANCH_RESOLVER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clk        = 1'b0;
   logic             reset      = 1'b0;
   logic             pred_valid = 1'b0;
   logic [IDX_W-1:0] pred_idx   = '0;
   logic             pred_taken = 1'b0;
   logic             res_valid  = 1'b0;
   logic             res_taken  = 1'b0;
   logic             pred_ready;
   logic             upd_valid;
   logic [IDX_W-1:0] upd_idx;
   logic             upd_taken;
   logic             mispredict;
   logic             orphan_err;
   logic [CNT_W-1:0] mismatch_cnt;
   logic [CNT_W-1:0] branch_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   branch_resolver #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pred_valid   (pred_valid),
      .pred_ready   (pred_ready),
      .pred_idx     (pred_idx),
      .pred_taken   (pred_taken),
      .res_valid    (res_valid),
      .res_taken    (res_taken),
      .upd_valid    (upd_valid),
      .upd_idx      (upd_idx),
      .upd_taken    (upd_taken),
      .mispredict   (mispredict),
      .orphan_err   (orphan_err),
      .mismatch_cnt (mismatch_cnt),
      .branch_cnt   (branch_cnt)
   );

   typedef struct {
      bit pv; int pidx; bit pt; bit rv; bit rt;       // inputs for one cycle
      bit ready;                                      // pred_ready before the edge
      bit uv; int uidx; bit ut; bit mp; bit orph;     // outputs after the edge
      int bc; int mc;                                 // counters with stats enabled
   } vec_t;

   typedef struct { int idx; bit taken; } m_entry_t;

   // Reference model state for the randomized phase.
   m_entry_t m_q[$];
   bit       m_flush;
   int       m_bc;
   int       m_mc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit pv, input int pidx, input bit pt, input bit rv, input bit rt);
      pred_valid = pv;
      pred_idx   = IDX_W'(pidx);
      pred_taken = pt;
      res_valid  = rv;
      res_taken  = rt;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic vec_t v(bit pv, int pidx, bit pt, bit rv, bit rt, bit rdy,
                              bit uv, int uidx, bit ut, bit mp, bit orph, int bc, int mc);
      vec_t r;
      r.pv = pv; r.pidx = pidx; r.pt = pt; r.rv = rv; r.rt = rt; r.ready = rdy;
      r.uv = uv; r.uidx = uidx; r.ut = ut; r.mp = mp; r.orph = orph; r.bc = bc; r.mc = mc;
      return r;
   endfunction

   task automatic check_outputs(input string tag, input bit uv, input int uidx, input bit ut,
                                input bit mp, input bit orph, input int bc, input int mc);
      check({tag, " upd_valid"}, upd_valid, uv);
      check({tag, " mispredict"}, mispredict, mp);
      check({tag, " orphan_err"}, orphan_err, orph);
      if (uv) begin
         check({tag, " upd_idx"}, upd_idx, uidx);
         check({tag, " upd_taken"}, upd_taken, ut);
      end
      check({tag, " branch_cnt"}, branch_cnt, STATS ? bc : 0);
      check({tag, " mismatch_cnt"}, mismatch_cnt, STATS ? mc : 0);
   endtask

   // One randomized cycle checked against the queue model.
   task automatic rand_cycle(input int n);
      bit pv, pt, rv, rt, e_ready, e_uv, e_ut, e_mp, e_or;
      int pidx, e_uidx;
      m_entry_t e;
      pv   = ($urandom_range(0, 99) < 60);
      pidx = $urandom_range(0, (1 << IDX_W) - 1);
      pt   = 1'($urandom_range(0, 1));
      rv   = ($urandom_range(0, 99) < 45);
      rt   = 1'($urandom_range(0, 1));
      e_ready = !m_flush && (m_q.size() < DEPTH);
      drive(pv, pidx, pt, rv, rt);
      #1;
      check($sformatf("rand%0d ready", n), pred_ready, e_ready);
      e_uv = 0; e_uidx = 0; e_ut = 0; e_mp = 0; e_or = 0;
      if (m_flush) begin
         m_q.delete();
         m_flush = 0;
      end else begin
         if (rv) begin
            if (m_q.size() == 0) begin
               e_or = 1;
            end else begin
               e = m_q.pop_front();
               e_uv = 1; e_uidx = e.idx; e_ut = rt;
               if (m_bc < CNT_MAX) m_bc++;
               if (e.taken != rt) begin
                  e_mp = 1;
                  if (m_mc < CNT_MAX) m_mc++;
                  m_flush = 1;
               end
            end
         end
         if (pv && e_ready) begin
            e.idx = pidx; e.taken = pt;
            m_q.push_back(e);
         end
      end
      tick();
      check_outputs($sformatf("rand%0d", n), e_uv, e_uidx, e_ut, e_mp, e_or, m_bc, m_mc);
   endtask

   initial begin
      vec_t tbl[$];

      // Directed sequence, starting from a freshly armed resolver.
      //               pv idx pt rv rt rdy uv uidx ut mp or bc mc
      tbl.push_back(v(1,  3, 1, 0, 0, 1,  0,  0, 0, 0, 0, 0, 0)); // push 3 T
      tbl.push_back(v(0,  0, 0, 1, 1, 1,  1,  3, 1, 0, 0, 1, 0)); // resolve T: match
      tbl.push_back(v(0,  0, 0, 0, 0, 1,  0,  0, 0, 0, 0, 1, 0));
      tbl.push_back(v(1,  1, 0, 0, 0, 1,  0,  0, 0, 0, 0, 1, 0)); // push 1 N
      tbl.push_back(v(1,  2, 1, 0, 0, 1,  0,  0, 0, 0, 0, 1, 0)); // push 2 T
      tbl.push_back(v(1,  5, 1, 0, 0, 1,  0,  0, 0, 0, 0, 1, 0)); // push 5 T
      tbl.push_back(v(0,  0, 0, 1, 1, 1,  1,  1, 1, 1, 0, 2, 1)); // resolve T: mispredict
      tbl.push_back(v(1,  9, 0, 1, 0, 0,  0,  0, 0, 0, 0, 2, 1)); // FLUSH: push refused, res ignored
      tbl.push_back(v(0,  0, 0, 1, 0, 1,  0,  0, 0, 0, 1, 2, 1)); // FIFO empty: orphan
      tbl.push_back(v(1, 10, 0, 0, 0, 1,  0,  0, 0, 0, 0, 2, 1)); // fill to DEPTH
      tbl.push_back(v(1, 11, 1, 0, 0, 1,  0,  0, 0, 0, 0, 2, 1));
      tbl.push_back(v(1, 12, 0, 0, 0, 1,  0,  0, 0, 0, 0, 2, 1));
      tbl.push_back(v(1, 13, 1, 0, 0, 1,  0,  0, 0, 0, 0, 2, 1));
      tbl.push_back(v(1, 14, 1, 1, 0, 0,  1, 10, 0, 0, 0, 3, 1)); // full: pop, push refused
      tbl.push_back(v(1, 14, 1, 0, 0, 1,  0,  0, 0, 0, 0, 3, 1)); // push accepted next cycle
      tbl.push_back(v(0,  0, 0, 1, 1, 0,  1, 11, 1, 0, 0, 4, 1)); // full again: pop only
      tbl.push_back(v(1, 15, 0, 1, 0, 1,  1, 12, 0, 0, 0, 5, 1)); // push + matching pop
      tbl.push_back(v(0,  0, 0, 1, 1, 1,  1, 13, 1, 0, 0, 6, 1)); // drain
      tbl.push_back(v(0,  0, 0, 1, 1, 1,  1, 14, 1, 0, 0, 7, 1));
      tbl.push_back(v(0,  0, 0, 1, 0, 1,  1, 15, 0, 0, 0, 8, 1));
      tbl.push_back(v(1,  6, 1, 0, 0, 1,  0,  0, 0, 0, 0, 8, 1)); // push 6 T
      tbl.push_back(v(1,  7, 0, 1, 0, 1,  1,  6, 0, 1, 0, 9, 2)); // push 7 + mispredict
      tbl.push_back(v(0,  0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 9, 2)); // FLUSH drops 7
      tbl.push_back(v(0,  0, 0, 1, 0, 1,  0,  0, 0, 0, 1, 9, 2)); // orphan: 7 was discarded

      // Reset state.
      #2;
      check("reset pred_ready", pred_ready, 0);
      check_outputs("reset", 0, 0, 0, 0, 0, 0, 0);
      check("reset upd_idx", upd_idx, 0);
      check("reset upd_taken", upd_taken, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("ready before first edge", pred_ready, 0);
      tick();

      foreach (tbl[i]) begin
         drive(tbl[i].pv, tbl[i].pidx, tbl[i].pt, tbl[i].rv, tbl[i].rt);
         #1;
         check($sformatf("row%0d pred_ready", i), pred_ready, tbl[i].ready);
         tick();
         check_outputs($sformatf("row%0d", i), tbl[i].uv, tbl[i].uidx, tbl[i].ut,
                       tbl[i].mp, tbl[i].orph, tbl[i].bc, tbl[i].mc);
      end

      // Reset with three entries in flight.
      drive(1, 2, 0, 0, 0); tick();
      drive(1, 4, 1, 0, 0); tick();
      drive(1, 8, 0, 1, 0); tick();           // resolves 2 and pushes 8: pops upd_valid
      drive(1, 9, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      check("midreset pred_ready", pred_ready, 0);
      check("midreset upd_idx", upd_idx, 0);
      check("midreset upd_taken", upd_taken, 0);
      check_outputs("midreset", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      drive(0, 0, 0, 1, 0);
      #1;
      check("post-reset pred_ready", pred_ready, 1);
      tick();
      check_outputs("post-reset drop", 0, 0, 0, 0, 1, 0, 0);
      drive(1, 3, 1, 0, 0); tick();
      check_outputs("post-reset push", 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 1); tick();
      check_outputs("post-reset resolve", 1, 3, 1, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0); tick();
      check_outputs("post-reset idle", 0, 0, 0, 0, 0, 1, 0);

      // Randomized run from a clean reset, checked against the queue model.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      m_q.delete();
      m_flush = 0;
      m_bc    = 0;
      m_mc    = 0;
      for (int n = 0; n < 3000; n++) begin
         rand_cycle(n);
      end
      drive(0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
